ibex_rf_wb_arbiter: RTL and testbench

IBEX_RF_WB_ARBITER -- requirements
Module: ibex_rf_wb_arbiter

---
 rtl/ibex_rf_wb_pkg.sv | 12 +
 rtl/ibex_rf_wb_arbiter_if.sv | 47 ++++
 rtl/ibex_rf_wb_fifo.sv | 80 ++++++++
 rtl/ibex_rf_wb_arbiter.sv | 143 ++++++++++++++
 tb/tb_ibex_rf_wb_arbiter.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/ibex_rf_wb_pkg.sv
// Shared widths and the register-file write record for the write-back arbiter.
package ibex_rf_wb_pkg;

    localparam int unsigned RegAddrW = 5;
    localparam int unsigned RegDataW = 32;

    typedef struct packed {
        logic [RegAddrW-1:0] addr;
        logic [RegDataW-1:0] data;
    } rf_wr_t;

endpackage

// File: rtl/ibex_rf_wb_arbiter_if.sv
// Bus bundle between the core pipeline (master) and the write-back arbiter (slave).
interface ibex_rf_wb_arbiter_if;
    import ibex_rf_wb_pkg::*;

    logic                ex_valid_i;
    logic                ex_ready_o;
    logic [RegAddrW-1:0] ex_waddr_i;
    logic [RegDataW-1:0] ex_wdata_i;

    logic                lsu_rvalid_i;
    logic [RegAddrW-1:0] lsu_waddr_i;
    logic [RegDataW-1:0] lsu_wdata_i;

    logic                we_a_o;
    logic [RegAddrW-1:0] waddr_a_o;
    logic [RegDataW-1:0] wdata_a_o;

    logic [RegAddrW-1:0] raddr_a_i;
    logic [RegAddrW-1:0] raddr_b_i;
    logic                hazard_a_o;
    logic                hazard_b_o;
    logic                fwd_valid_a_o;
    logic [RegDataW-1:0] fwd_data_a_o;
    logic                fwd_valid_b_o;
    logic [RegDataW-1:0] fwd_data_b_o;

    modport slave (
        input  ex_valid_i, ex_waddr_i, ex_wdata_i,
        input  lsu_rvalid_i, lsu_waddr_i, lsu_wdata_i,
        input  raddr_a_i, raddr_b_i,
        output ex_ready_o,
        output we_a_o, waddr_a_o, wdata_a_o,
        output hazard_a_o, hazard_b_o,
        output fwd_valid_a_o, fwd_data_a_o, fwd_valid_b_o, fwd_data_b_o
    );

    modport master (
        output ex_valid_i, ex_waddr_i, ex_wdata_i,
        output lsu_rvalid_i, lsu_waddr_i, lsu_wdata_i,
        output raddr_a_i, raddr_b_i,
        input  ex_ready_o,
        input  we_a_o, waddr_a_o, wdata_a_o,
        input  hazard_a_o, hazard_b_o,
        input  fwd_valid_a_o, fwd_data_a_o, fwd_valid_b_o, fwd_data_b_o
    );

endinterface

// File: rtl/ibex_rf_wb_fifo.sv
// EX result buffer; exposes entries oldest-first for hazard search.
// Entry data is only exported when IBEX_RF_WB_FWD_EN is defined.
module ibex_rf_wb_fifo
    import ibex_rf_wb_pkg::*;
#(
    parameter int unsigned Depth = 2
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                push,
    input  rf_wr_t              push_data,
    input  logic                pop,
    output rf_wr_t              head,
    output logic                full,
    output logic                empty,
    output logic [RegAddrW-1:0] age_addr [Depth],
    output logic [Depth-1:0]    age_valid
`ifdef IBEX_RF_WB_FWD_EN
    ,
    output logic [RegDataW-1:0] age_data [Depth]
`endif
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = PtrW + 1;

    typedef logic [PtrW-1:0] ptr_t;
    typedef logic [CntW-1:0] cnt_t;

    rf_wr_t mem [Depth];
    ptr_t   rd_ptr;
    ptr_t   wr_ptr;
    cnt_t   count;
    logic   do_push;
    logic   do_pop;

    assign full    = (count == cnt_t'(Depth));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Depth is a power of two, so pointer overflow is the modulo wrap.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + ptr_t'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + ptr_t'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + cnt_t'(1);
                2'b01:   count <= count - cnt_t'(1);
                default: count <= count;
            endcase
        end
    end

    always_comb begin
        for (int i = 0; i < Depth; i++) begin
            age_addr[i]  = mem[rd_ptr + ptr_t'(i)].addr;
            age_valid[i] = (cnt_t'(i) < count);
`ifdef IBEX_RF_WB_FWD_EN
            age_data[i]  = mem[rd_ptr + ptr_t'(i)].data;
`endif
        end
    end

endmodule

// File: rtl/ibex_rf_wb_arbiter.sv
// Register-file write-back arbiter: LSU first, then buffered EX, then EX bypass.
// Define IBEX_RF_WB_FWD_EN to drive the forwarding outputs; otherwise they are tied to 0.
module ibex_rf_wb_arbiter
    import ibex_rf_wb_pkg::*;
#(
    parameter int unsigned FifoDepth = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    ibex_rf_wb_arbiter_if.slave  bus
);

    logic                lsu_sel;
    logic                ex_keep;
    logic                ex_sel;
    logic                fifo_push;
    logic                fifo_pop;
    logic                fifo_full;
    logic                fifo_empty;
    rf_wr_t              fifo_head;
    rf_wr_t              ex_wr;
    logic [RegAddrW-1:0] age_addr [FifoDepth];
    logic [FifoDepth-1:0] age_valid;
    logic                we_d;
    logic                we_q;
    rf_wr_t              wr_d;
    rf_wr_t              wr_q;
    logic [RegAddrW-1:0] raddr [2];
    logic [1:0]          hazard;
`ifdef IBEX_RF_WB_FWD_EN
    logic [RegDataW-1:0] age_data [FifoDepth];
    logic [RegDataW-1:0] fwd_data [2];
`endif

    assign ex_wr = '{addr: bus.ex_waddr_i, data: bus.ex_wdata_i};

    // x0 results still complete the EX handshake but are otherwise discarded.
    assign lsu_sel   = bus.lsu_rvalid_i && (bus.lsu_waddr_i != '0);
    assign ex_keep   = bus.ex_valid_i && !fifo_full && (bus.ex_waddr_i != '0);
    assign fifo_pop  = !lsu_sel && !fifo_empty;
    assign ex_sel    = !lsu_sel && fifo_empty && ex_keep;
    assign fifo_push = ex_keep && !ex_sel;

    ibex_rf_wb_fifo #(
        .Depth (FifoDepth)
    ) u_fifo (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .push      (fifo_push),
        .push_data (ex_wr),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .age_addr  (age_addr),
        .age_valid (age_valid)
`ifdef IBEX_RF_WB_FWD_EN
        ,
        .age_data  (age_data)
`endif
    );

    always_comb begin
        we_d = 1'b1;
        wr_d = '0;
        if (lsu_sel) begin
            wr_d = '{addr: bus.lsu_waddr_i, data: bus.lsu_wdata_i};
        end else if (fifo_pop) begin
            wr_d = fifo_head;
        end else if (ex_sel) begin
            wr_d = ex_wr;
        end else begin
            we_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            we_q <= 1'b0;
            wr_q <= '0;
        end else begin
            we_q <= we_d;
            wr_q <= wr_d;
        end
    end

    assign bus.ex_ready_o = !fifo_full;
    assign bus.we_a_o     = we_q;
    assign bus.waddr_a_o  = wr_q.addr;
    assign bus.wdata_a_o  = wr_q.data;

    assign raddr[0] = bus.raddr_a_i;
    assign raddr[1] = bus.raddr_b_i;

    // Sources checked oldest to youngest so the last hit holds the newest data.
    always_comb begin
        hazard = '0;
        for (int p = 0; p < 2; p++) begin
`ifdef IBEX_RF_WB_FWD_EN
            fwd_data[p] = '0;
`endif
            if (we_q && (wr_q.addr == raddr[p])) begin
                hazard[p] = 1'b1;
`ifdef IBEX_RF_WB_FWD_EN
                fwd_data[p] = wr_q.data;
`endif
            end
            for (int i = 0; i < FifoDepth; i++) begin
                if (age_valid[i] && (age_addr[i] == raddr[p])) begin
                    hazard[p] = 1'b1;
`ifdef IBEX_RF_WB_FWD_EN
                    fwd_data[p] = age_data[i];
`endif
                end
            end
            if (ex_keep && (bus.ex_waddr_i == raddr[p])) begin
                hazard[p] = 1'b1;
`ifdef IBEX_RF_WB_FWD_EN
                fwd_data[p] = bus.ex_wdata_i;
`endif
            end
            if ((raddr[p] == '0) || !rst_ni) begin
                hazard[p] = 1'b0;
            end
        end
    end

    assign bus.hazard_a_o = hazard[0];
    assign bus.hazard_b_o = hazard[1];

`ifdef IBEX_RF_WB_FWD_EN
    assign bus.fwd_valid_a_o = hazard[0];
    assign bus.fwd_data_a_o  = hazard[0] ? fwd_data[0] : '0;
    assign bus.fwd_valid_b_o = hazard[1];
    assign bus.fwd_data_b_o  = hazard[1] ? fwd_data[1] : '0;
`else
    assign bus.fwd_valid_a_o = 1'b0;
    assign bus.fwd_data_a_o  = '0;
    assign bus.fwd_valid_b_o = 1'b0;
    assign bus.fwd_data_b_o  = '0;
`endif

endmodule

// File: tb/tb_ibex_rf_wb_arbiter.sv
// Randomized bench for ibex_rf_wb_arbiter against a queue-based reference model.
module tb_ibex_rf_wb_arbiter;
    import ibex_rf_wb_pkg::*;

    localparam int FifoDepth = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    rf_wr_t      m_q [$];
    logic        m_we = 1'b0;
    logic [4:0]  m_waddr = '0;
    logic [31:0] m_wdata = '0;

    ibex_rf_wb_arbiter_if bus ();

    ibex_rf_wb_arbiter #(.FifoDepth(FifoDepth)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Pending writes ordered oldest to youngest; the last match wins.
    function automatic void ref_hazard(input logic [4:0] ra, input bit keep, input logic [4:0] ea,
                                       input logic [31:0] ed, output bit hz, output logic [31:0] fd);
        hz = 1'b0;
        fd = '0;
        if (ra == 5'd0) return;
        if (m_we && m_waddr == ra) begin hz = 1'b1; fd = m_wdata; end
        foreach (m_q[i]) if (m_q[i].addr == ra) begin hz = 1'b1; fd = m_q[i].data; end
        if (keep && ea == ra) begin hz = 1'b1; fd = ed; end
    endfunction

    task automatic check_read(input string tag, input logic got_hz, input logic got_fv,
                              input logic [31:0] got_fd, input bit hz, input logic [31:0] fd);
        chk({"hazard_", tag}, got_hz, hz);
`ifdef IBEX_RF_WB_FWD_EN
        chk({"fwd_valid_", tag}, got_fv, hz);
        chk({"fwd_data_", tag}, got_fd, fd);
`else
        chk({"fwd_valid_", tag}, got_fv, 0);
        chk({"fwd_data_", tag}, got_fd, 0);
`endif
    endtask

    // Called just after a rising edge; returns whether the EX result was accepted.
    task automatic cycle(input bit lv, input logic [4:0] la, input logic [31:0] ld,
                         input bit ev, input logic [4:0] ea, input logic [31:0] ed,
                         input logic [4:0] ra, input logic [4:0] rb, output bit accepted);
        bit          exp_ready, keep, hz;
        logic [31:0] fd;
        rf_wr_t      nxt;
        bit          nxt_we;
        bus.lsu_rvalid_i = lv; bus.lsu_waddr_i = la; bus.lsu_wdata_i = ld;
        bus.ex_valid_i = ev; bus.ex_waddr_i = ea; bus.ex_wdata_i = ed;
        bus.raddr_a_i = ra; bus.raddr_b_i = rb;
        @(negedge clk);
        exp_ready = (m_q.size() < FifoDepth);
        chk("ex_ready", bus.ex_ready_o, exp_ready);
        accepted = ev && exp_ready;
        keep = accepted && (ea != 5'd0);
        ref_hazard(ra, keep, ea, ed, hz, fd);
        check_read("a", bus.hazard_a_o, bus.fwd_valid_a_o, bus.fwd_data_a_o, hz, fd);
        ref_hazard(rb, keep, ea, ed, hz, fd);
        check_read("b", bus.hazard_b_o, bus.fwd_valid_b_o, bus.fwd_data_b_o, hz, fd);
        nxt_we = 1'b1;
        nxt = '0;
        if (lv && la != 5'd0) nxt = '{addr: la, data: ld};
        else if (m_q.size() > 0) nxt = m_q.pop_front();
        else if (keep) begin nxt = '{addr: ea, data: ed}; keep = 1'b0; end
        else nxt_we = 1'b0;
        if (keep) m_q.push_back('{addr: ea, data: ed});
        m_we = nxt_we; m_waddr = nxt.addr; m_wdata = nxt.data;
        @(posedge clk);
        #1;
        chk("we_a", bus.we_a_o, m_we);
        if (m_we) begin
            chk("waddr_a", bus.waddr_a_o, m_waddr);
            chk("wdata_a", bus.wdata_a_o, m_wdata);
        end
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int k = 0; k < n; k++) cycle(0, 0, 0, 0, 0, 0, 0, 0, acc);
    endtask

    initial begin
        bit acc;
        int ex_idx;
        int guard;
        bus.lsu_rvalid_i = 0; bus.lsu_waddr_i = 0; bus.lsu_wdata_i = 0;
        bus.ex_valid_i = 1; bus.ex_waddr_i = 5'd3; bus.ex_wdata_i = 32'h1;
        bus.raddr_a_i = 5'd3; bus.raddr_b_i = 5'd0;
        #12;
        chk("rst_we", bus.we_a_o, 0);
        chk("rst_waddr", bus.waddr_a_o, 0);
        chk("rst_wdata", bus.wdata_a_o, 0);
        chk("rst_ready", bus.ex_ready_o, 1);
        chk("rst_hazard_a", bus.hazard_a_o, 0);
        bus.ex_valid_i = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // EX only, straight through the bypass
        cycle(0, 0, 0, 1, 5'd1, 32'h0F0F0F0F, 5'd1, 0, acc);
        chk("ex_only_fifo_empty", bus.ex_ready_o, 1);
        idle(1);

        // LSU and EX collide: LSU first, EX the following cycle
        cycle(1, 5'd2, 32'hF0F0F0F0, 1, 5'd3, 32'h12345678, 5'd3, 5'd2, acc);
        cycle(0, 0, 0, 0, 0, 0, 5'd3, 5'd2, acc);
        idle(1);

        // Backpressure: LSU busy four cycles, EX offered continuously
        ex_idx = 0;
        for (int c = 0; c < 4; c++) begin
            cycle(1, 5'd7, 32'h700 + c, 1, 5'(4 + ex_idx), 32'hA0 + ex_idx, 5'd4, 5'd5, acc);
            if (acc) ex_idx++;
        end
        chk("bp_ready_low", bus.ex_ready_o, 0);
        chk("bp_two_accepted", ex_idx, 2);
        guard = 0;
        while (ex_idx < 3 && guard < 10) begin
            cycle(0, 0, 0, 1, 5'(4 + ex_idx), 32'hA0 + ex_idx, 5'd6, 5'd4, acc);
            if (acc) ex_idx++;
            guard++;
        end
        chk("bp_r6_accepted", ex_idx, 3);
        idle(3);

        // Writes to x0 from both sources are dropped
        for (int c = 0; c < 3; c++) cycle(1, 5'd0, 32'hBAD, 1, 5'd0, 32'hBAD0, 5'd0, 5'd0, acc);
        idle(1);

        // Buffered r5 visible as hazard / forward source
        cycle(1, 5'd9, 32'h99, 1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0, acc);
        cycle(1, 5'd9, 32'h98, 0, 0, 0, 5'd5, 5'd0, acc);
        idle(2);

        // Reset while two entries are buffered
        cycle(1, 5'd9, 32'h91, 1, 5'd10, 32'hAAAA0010, 0, 0, acc);
        cycle(1, 5'd9, 32'h92, 1, 5'd11, 32'hAAAA0011, 0, 0, acc);
        bus.lsu_rvalid_i = 0; bus.ex_valid_i = 0; bus.raddr_a_i = 5'd10; bus.raddr_b_i = 5'd11;
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_we", bus.we_a_o, 0);
        chk("midrst_ready", bus.ex_ready_o, 1);
        chk("midrst_hazard_a", bus.hazard_a_o, 0);
        chk("midrst_hazard_b", bus.hazard_b_o, 0);
        m_q.delete();
        m_we = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int c = 0; c < 4; c++) cycle(0, 0, 0, 0, 0, 0, 5'd10, 5'd11, acc);

        // Random traffic
        for (int c = 0; c < 400; c++) begin
            cycle(($urandom_range(0, 99) < 40), 5'($urandom_range(0, 7)), $urandom,
                  ($urandom_range(0, 99) < 60), 5'($urandom_range(0, 7)), $urandom,
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), acc);
        end
        idle(4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
